perf_monitor: RTL
=================

# perf_monitor

Pipeline event monitor that sits directly downstream of the pipelined CPU's hazard, control and flush logic. It counts run cycles, true data-hazard stalls, flushes and retired instructions. It also raises a sticky halt once a programmed cycle budget is exhausted. Simulation benches and debug readout read its counters through a registered select port instead of probing internal CPU signals.

## Interface
- CNT_W, 32, width of every event counter
- MAX_CYCLE, 70, cycle budget; halt when the cycle counter reaches this value (must be ≥1 and < 2^CNT_W)

- clk_i  in  1  clock, rising-edge
- rst_i  in  1  asynchronous active-low reset
- start_i  in  1  CPU start; counting is enabled only while high
- stall_i  in  1  hazard-detection stall request (MUX control into ID)
- jump_i  in  1  jump decoded in ID this cycle
- branch_i  in  1  branch decoded in ID this cycle
- flush_i  in  1  IF/ID flush asserted this cycle
- retire_i  in  1  a non-bubble instruction leaves MEM/WB this cycle
- clear_i  in  1  synchronous clear of all counters
- sel_i  in  3  counter select for data_o
- data_o  out  CNT_W  registered readout of the selected counter
- halt_o  out  1  sticky cycle-budget-exhausted flag
- state_o  out  2  current FSM state

## Operation
- FSM states: IDLE=2'b00, RUN=2'b01, HALT=2'b10. Encoding 2'b11 is unreachable; if it occurs, the next state is IDLE.
- IDLE→RUN when start_i=1 at a rising edge.
- RUN→IDLE when start_i=0. This is a pause: counters hold their values.
- RUN→HALT at the edge where the cycle counter's next value equals MAX_CYCLE.
- HALT is sticky. It is left only by reset (→IDLE) or clear_i (→IDLE).
- Counters (all CNT_W bits, unsigned) increment only in cycles spent in RUN, including the final cycle that transitions to HALT:
  - cyc: increments every RUN cycle.
  - stl: increments when stall_i & ~jump_i & ~branch_i. A stall raised for control transfer is not counted.
  - fls: increments when flush_i.
  - ret: increments when retire_i.
- Every counter saturates at 2^CNT_W−1 and never wraps. For cyc this cannot occur because halt happens first.
- clear_i has priority over every event in the same cycle:
  - All four counters go to 0; events in that cycle are dropped.
  - halt_o goes to 0.
  - HALT→IDLE; IDLE and RUN are unchanged.
- Readout mux on sel_i:
  - 0=cyc, 1=stl, 2=fls, 3=ret.
  - 4 = zero-extended {halt_o, state_o}.
  - 5..7 = 0.
- data_o is registered and loaded every cycle, in all states, from the pre-edge counter values.

## Timing
- Reset (rst_i low, asynchronous, takes effect immediately): state IDLE, all counters 0, data_o 0, halt_o 0, state_o 2'b00.
- Counter update latency: an event present before rising edge N is visible in the counter after edge N.
- data_o latency: sel_i and counter value at edge N appear on data_o after edge N. An event counted at edge N therefore shows on data_o after edge N+1.
- halt_o and state_o=HALT assert at the same edge that cyc becomes MAX_CYCLE.
- First RUN cycle: the edge that samples start_i=1 in IDLE only changes the state. Counting starts at the next edge.
- Reset asserted mid-RUN clears everything asynchronously. After release the block waits in IDLE for start_i.
- All inputs are sampled only at rising edges; no combinational path from any input to any output.

## Test plan
- Reset mid-run: start_i=1 for 10 edges, then pulse rst_i low between edges → counters, data_o, halt_o and state_o all read 0 immediately; state_o stays 2'b00 until start_i is sampled again.
- Budget halt: MAX_CYCLE=70, start_i held high, no events → halt_o rises at the 70th counting edge (71st edge after start_i is sampled); sel_i=0 gives data_o=70; 20 further edges leave data_o=70 and halt_o=1.
- Stall qualification: 5 cycles with stall_i=1, 2 of them with branch_i=1 and 1 with jump_i=1 → stl=2. Then flush_i for 4 cycles → sel_i=2 gives data_o=4 one edge after selection.
- Pause: run 10 cycles, drop start_i for 5 cycles with retire_i=1, then resume for 3 retire cycles → cyc=13, ret=3.
- Saturation: CNT_W=4, MAX_CYCLE=15, retire_i=1 for the whole run → ret=15, cyc=15, halt_o=1, and no wrap to 0.
- Clear priority: in HALT, assert clear_i together with flush_i → next edge state_o=IDLE, halt_o=0, fls=0, cyc=0; sel_i=4 then gives data_o=0.

Source files
------------

// File: rtl/perf_monitor_if.sv
// Event and readout bundle between the CPU pipeline control logic and perf_monitor.
// The CPU side (or a bench) is the master; the monitor is the slave.
interface perf_monitor_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             stall_i;
    logic             jump_i;
    logic             branch_i;
    logic             flush_i;
    logic             retire_i;
    logic             clear_i;
    logic [2:0]       sel_i;
    logic [CNT_W-1:0] data_o;
    logic             halt_o;
    logic [1:0]       state_o;

    modport master (
        output start_i, stall_i, jump_i, branch_i, flush_i, retire_i, clear_i, sel_i,
        input  data_o, halt_o, state_o
    );

    modport slave (
        input  start_i, stall_i, jump_i, branch_i, flush_i, retire_i, clear_i, sel_i,
        output data_o, halt_o, state_o
    );
endinterface

// File: rtl/perf_monitor.sv
// Pipeline event monitor: counts run cycles, data stalls, flushes and retires,
// and raises a sticky halt when the cycle budget is used up.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; counters hold
// RUN   | counting while start_i is high; start_i low pauses back to IDLE
// HALT  | cycle budget exhausted; sticky until clear_i or reset
module perf_monitor #(
    parameter int CNT_W     = 32,
    parameter int MAX_CYCLE = 70
) (
    input  logic           clk_i,
    input  logic           rst_i,
    perf_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLE);

    state_t           state;
    logic             halt;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] stl;
    logic [CNT_W-1:0] fls;
    logic [CNT_W-1:0] ret;
    logic [CNT_W-1:0] data;
    logic [CNT_W-1:0] cyc_nxt;
    logic             data_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign cyc_nxt    = sat_inc(cyc);
    // A stall raised for a control transfer is not a data hazard.
    assign data_stall = bus.stall_i & ~bus.jump_i & ~bus.branch_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            halt  <= 1'b0;
            cyc   <= '0;
            stl   <= '0;
            fls   <= '0;
            ret   <= '0;
            data  <= '0;
        end else begin
            // Readout always reflects the values held before this edge.
            case (bus.sel_i)
                3'd0:    data <= cyc;
                3'd1:    data <= stl;
                3'd2:    data <= fls;
                3'd3:    data <= ret;
                3'd4:    data <= {{(CNT_W-3){1'b0}}, halt, state};
                default: data <= '0;
            endcase

            if (bus.clear_i) begin
                cyc  <= '0;
                stl  <= '0;
                fls  <= '0;
                ret  <= '0;
                halt <= 1'b0;
                if (state != IDLE && state != RUN) begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start_i) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (!bus.start_i) begin
                            state <= IDLE;
                        end else begin
                            cyc <= cyc_nxt;
                            if (data_stall) begin
                                stl <= sat_inc(stl);
                            end
                            if (bus.flush_i) begin
                                fls <= sat_inc(fls);
                            end
                            if (bus.retire_i) begin
                                ret <= sat_inc(ret);
                            end
                            if (cyc_nxt == MAX_C) begin
                                state <= HALT;
                                halt  <= 1'b1;
                            end
                        end
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.data_o  = data;
    assign bus.halt_o  = halt;
    assign bus.state_o = state;
endmodule
